// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
// Provides the FSM state encoding and the datapath nibble width.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_fa4.sv
// 4-bit ripple-carry adder built from a chain of 1-bit full adders.
// Ports: a, b (4-bit operands), cin (carry-in), sum (4-bit), cout.
module fa_4bit_using_fa_1bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder that time-shares one 4-bit adder, one nibble per clock.
// Ports: clk, rst, start, a_in, b_in, cin_in -> busy, done, sum_out, cout_out.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a_in,
    input  logic [NIB_W*NIBBLES-1:0] b_in,
    input  logic                     cin_in,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum_out,
    output logic                     cout_out
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t            r_state;
    logic [W-1:0]      r_a_sh;
    logic [W-1:0]      r_b_sh;
    // Only the upper W-4 bits of the sum shifter are ever read back;
    // the newest nibble is merged combinationally.
    logic [W-NIB_W-1:0] r_sum_sh;
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_busy;
    logic              r_done;
    logic [CW-1:0]     r_cnt;

    logic [NIB_W-1:0]  w_nib;
    logic              w_cout;
    logic [W-1:0]      w_sum_next;

    fa_4bit_using_fa_1bit u_fa (
        .a    (r_a_sh[NIB_W-1:0]),
        .b    (r_b_sh[NIB_W-1:0]),
        .cin  (r_carry),
        .sum  (w_nib),
        .cout (w_cout)
    );

    // New nibble enters from the MSB end so the LSB nibble lands at bit 0.
    assign w_sum_next = {w_nib, r_sum_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a_in;
                        r_b_sh  <= b_in;
                        r_carry <= cin_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum_sh <= w_sum_next[W-1:NIB_W];
                    r_carry  <= w_cout;
                    r_a_sh   <= r_a_sh >> NIB_W;
                    r_b_sh   <= r_b_sh >> NIB_W;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum_out  = r_sum;
    assign cout_out = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (NIBBLES = 4).
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_nibble_serial_adder_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct {
        logic [W:0] val;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   next_ok = 0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    logic [W:0] held = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, expv, cyc);
        end
    endtask

    // Monitor: done pops the scoreboard; otherwise result must hold.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy),
                32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.cyc));
                    chk("result", 32'({cout_out, sum_out}), 32'(e.val));
                    held = e.val;
                end
            end else begin
                chk("hold", 32'({cout_out, sum_out}), 32'(held));
            end
        end
    end

    // Reference: an accepted start at edge e busies e..e+N-1 and
    // reports a+b+cin after edge e+N; next start accepted from e+N+1.
    task automatic step(input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
        int e;
        @(negedge clk);
        start  = s;
        a_in   = a;
        b_in   = b;
        cin_in = c;
        e = cyc + 1;
        if (s && e >= next_ok) begin
            exp_t x;
            x.val = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            x.cyc = e + NIB;
            exp_q.push_back(x);
            busy_lo = e;
            busy_hi = e + NIB - 1;
            next_ok = e + NIB + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        exp_q.delete();
        busy_hi = -1;
        next_ok = 0;
        held = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'h0000);
        chk("rst_cout", 32'(cout_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        async_reset();

        step(1'b1, 16'h1234, 16'h4321, 1'b0);
        idle(7);
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        idle(7);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        idle(7);

        step(1'b1, 16'h00FF, 16'h0001, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b1, 16'h1111, 16'h1111, 1'b0);
        idle(7);

        step(1'b1, 16'h2222, 16'h3333, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #2;
        start = 1'b0;
        async_reset();

        step(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0001, 16'h0001, 1'b0);
        idle(8);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 5))
                0: ra = '1;
                1: rb = '1;
                default: ;
            endcase
            step($urandom_range(0, 2) != 0, ra, rb, 1'($urandom));
            if (i == 150) begin
                @(posedge clk);
                #3;
                start = 1'b0;
                async_reset();
            end
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
